// File: rtl/demux_pkg.sv
// Shared definitions for the DEMUX L2 lane scheduler: FSM encoding, lane count, default FIFO depth.
package demux_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   localparam int LANES         = 2;
   localparam int DEFAULT_DEPTH = 4;

endpackage

// File: rtl/lane_fifo.sv
// First-word fall-through byte FIFO for one output lane of the scheduler.
module lane_fifo
   import demux_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk_4f,
   input  logic             reset_L,
   input  logic             push,
   input  logic [7:0]       din,
   input  logic             pop,
   output logic [7:0]       dout,
   output logic             valid,
   output logic             full,
   output logic [PTR_W:0]   count
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   logic [7:0]       mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, rd_q;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   assign valid   = (count_q != '0);
   assign full    = (count_q == FULL_CNT);
   assign count   = count_q;
   assign do_push = push & ~full;
   assign do_pop  = pop & valid;
   // Gate the head with valid so the lane reads 0 while empty or held in reset.
   assign dout    = valid ? mem_q[rd_q] : 8'h00;

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_4f or negedge reset_L) begin
      if (!reset_L) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_4f) begin
      if (do_push) mem_q[wr_q] <= din;
   end

endmodule

// File: rtl/demux_lane_scheduler.sv
// Splits one byte stream onto two lanes in strict alternation, with per-lane FIFOs for back-pressure.
module demux_lane_scheduler
   import demux_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic       clk_4f,
   input  logic       reset_L,
   input  logic       enable,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic       ready_in,
   output logic [7:0] data_out0,
   output logic       valid_out0,
   input  logic       ready_out0,
   output logic [7:0] data_out1,
   output logic       valid_out1,
   input  logic       ready_out1,
   output logic       lane_sel,
   output logic [1:0] state
);

   state_e             state_q, state_d;
   logic               lane_sel_q, lane_sel_d;
   logic [LANES-1:0]   full;
   logic [PTR_W:0]     count0, count1;
   logic               accept;

   // Only registered state feeds ready_in; a full target lane stalls the whole stream.
   assign ready_in = (state_q == ST_RUN) & ~(lane_sel_q ? full[1] : full[0]);
   assign accept   = valid_in & ready_in;
   assign lane_sel = lane_sel_q;
   assign state    = state_q;

   always_comb begin
      state_d    = state_q;
      lane_sel_d = lane_sel_q ^ accept;
      case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!enable) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (enable) begin
               state_d = ST_RUN;
            end else if (count0 == '0 && count1 == '0) begin
               state_d    = ST_IDLE;
               lane_sel_d = 1'b0;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            lane_sel_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_4f or negedge reset_L) begin
      if (!reset_L) begin
         state_q    <= ST_IDLE;
         lane_sel_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         lane_sel_q <= lane_sel_d;
      end
   end

   lane_fifo #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_lane0 (
      .clk_4f  (clk_4f),
      .reset_L (reset_L),
      .push    (accept & ~lane_sel_q),
      .din     (data_in),
      .pop     (ready_out0),
      .dout    (data_out0),
      .valid   (valid_out0),
      .full    (full[0]),
      .count   (count0)
   );

   lane_fifo #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_lane1 (
      .clk_4f  (clk_4f),
      .reset_L (reset_L),
      .push    (accept & lane_sel_q),
      .din     (data_in),
      .pop     (ready_out1),
      .dout    (data_out1),
      .valid   (valid_out1),
      .full    (full[1]),
      .count   (count1)
   );

endmodule
